wishbone_initiator_bfm: RTL and testbench
=========================================

// Module: wishbone_initiator_bfm
// PURPOSE
//  Command-driven Wishbone (classic, single-beat) initiator with a registered bus side.
//  Software/test layer issues one read or write per req handshake; the block runs one
//  Wishbone cycle (cyc/stb/we/adr/dat_w) and returns captured dat_r on a response pulse.
//  Sits between the test-control layer and any Wishbone target in the testbench or SoC.
// PARAMETERS
//  ADDR_WIDTH      32    width of adr / req_adr
//  DATA_WIDTH      32    width of dat_r, dat_w, req_dat, rsp_dat
//  TIMEOUT_CYCLES  256   ack wait limit (used only with WB_INIT_TIMEOUT_EN)
// PORTS
//  clock      in   1           single clock, rising edge
//  reset      in   1           asynchronous, active-low reset
//  req_valid  in   1           command present
//  req_ready  out  1           command accepted when req_valid && req_ready
//  req_we     in   1           1 = write, 0 = read
//  req_adr    in   ADDR_WIDTH  target address
//  req_dat    in   DATA_WIDTH  write data (driven on dat_w for reads too)
//  rsp_valid  out  1           one-cycle response pulse
//  rsp_dat    out  DATA_WIDTH  dat_r sampled with ack
//  rsp_err    out  1           1 = cycle aborted by timeout
//  adr        out  ADDR_WIDTH  Wishbone address
//  dat_w      out  DATA_WIDTH  Wishbone write data
//  dat_r      in   DATA_WIDTH  Wishbone read data
//  cyc        out  1           bus cycle
//  stb        out  1           strobe
//  we         out  1           write enable
//  ack        in   1           target acknowledge
// BEHAVIOUR
//  - All outputs registered. Reset (reset==0, async): state IDLE; cyc, stb, we,
//    rsp_valid, rsp_err = 0; adr, dat_w, rsp_dat = 0; req_ready = 1 once deasserted.
//  - States: IDLE, BUS. req_ready = (state==IDLE).
//  - IDLE: on handshake at edge N, latch adr<=req_adr, dat_w<=req_dat, we<=req_we;
//    assert cyc=stb=1; go BUS. rsp_valid cleared every cycle unless set below.
//  - BUS: hold cyc/stb/adr/we/dat_w stable. On edge sampling ack=1: cyc=stb=we=0,
//    rsp_dat<=dat_r (reads and writes), rsp_err<=0, rsp_valid<=1 for one cycle; go IDLE.
//  - ack while not in BUS is ignored. ack is level-sampled; target may ack zero-wait.
//  - At least one cycle with cyc=0 between consecutive bus cycles, by construction
//    (IDLE lasts >=1 cycle), so a target with a registered ack cannot double-ack.
//  - Latency with registered-ack target: accept at N, ack seen at N+2, rsp_valid
//    high after N+2, next accept earliest at N+3.
//  - adr/dat_w retain last values in IDLE. No bursts, no byte selects, no err/rty.
//  - Reset mid-cycle: cyc/stb drop immediately; no response issued for that command.
// CONFIGURATION
//  WB_INIT_TIMEOUT_EN defined: counter starts on entering BUS; if TIMEOUT_CYCLES
//   edges pass without ack, drop cyc/stb, rsp_valid=1, rsp_err=1, rsp_dat=0, go IDLE.
//   Ack on the same edge the limit is reached wins (normal response).
//  Not defined: no counter; BUS waits indefinitely; rsp_err tied 0.
// STRUCTURE
//  Package wishbone_initiator_pkg: state enum (IDLE, BUS), default width constants.
//  Optional sub-module wb_init_timeout_ctr (counter + expiry flag), instantiated
//  only under WB_INIT_TIMEOUT_EN. Everything else in the top module.
// TESTING (target: ack_r <= stb&cyc registered, ack = ack_r&cyc&stb, dat_r = dat_w)
//  1 reset low 50ns, release -> cyc=stb=0, req_ready=1, rsp_valid=0 throughout reset.
//  2 write adr=0x1000 dat=0xDEADBEEF -> we=1 while cyc; rsp_valid 2 edges after accept,
//    rsp_dat=0xDEADBEEF, rsp_err=0.
//  3 read adr=0x4 req_dat=0x12345678 -> we=0, rsp_dat=0x12345678.
//  4 req_valid held high for 4 commands -> each cycle separated by >=1 cyc=0 cycle,
//    exactly 4 rsp_valid pulses, no extra acks.
//  5 reset asserted while cyc=1 -> cyc/stb drop at once, no rsp_valid, next command ok.
//  6 WB_INIT_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack tied 0 -> rsp_err=1, rsp_dat=0,
//    cyc=0 after 8 cycles.

Source files
------------

// File: rtl/wishbone_initiator_pkg.sv
// Shared types and default sizes for the Wishbone initiator BFM.
package wishbone_initiator_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUS  = 1'b1
   } state_t;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 256;

endpackage

// File: rtl/wb_init_timeout_ctr.sv
// Ack-wait counter: cleared on command accept, counts edges spent in BUS and
// flags expiry on the edge where TIMEOUT_CYCLES edges have elapsed.
module wb_init_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

   // cnt holds the number of BUS edges already passed, so this edge is the limit
   assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wishbone_initiator_bfm.sv
// Command-driven single-beat Wishbone classic initiator with registered bus outputs.
// Optional ack timeout enabled by defining WB_INIT_TIMEOUT_EN.
module wishbone_initiator_bfm
   import wishbone_initiator_pkg::*;
#(
   parameter int ADDR_WIDTH     = ADDR_W_DEF,
   parameter int DATA_WIDTH     = DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_adr,
   input  logic [DATA_WIDTH-1:0] req_dat,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_dat,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] adr,
   output logic [DATA_WIDTH-1:0] dat_w,
   input  logic [DATA_WIDTH-1:0] dat_r,
   output logic                  cyc,
   output logic                  stb,
   output logic                  we,
   input  logic                  ack
);

   state_t                  state, state_n;
   logic                    cyc_n, stb_n, we_n;
   logic [ADDR_WIDTH-1:0]   adr_n;
   logic [DATA_WIDTH-1:0]   dat_w_n, rsp_dat_n;
   logic                    rsp_valid_n, rsp_err_n;
   logic                    accept;
   logic                    timeout_hit;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && (state == IDLE);

`ifdef WB_INIT_TIMEOUT_EN
   wb_init_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clock   (clock),
      .reset   (reset),
      .clr     (accept),
      .en      (state == BUS),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_n     = state;
      cyc_n       = cyc;
      stb_n       = stb;
      we_n        = we;
      adr_n       = adr;
      dat_w_n     = dat_w;
      rsp_dat_n   = rsp_dat;
      rsp_err_n   = rsp_err;
      rsp_valid_n = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               adr_n   = req_adr;
               dat_w_n = req_dat;
               we_n    = req_we;
               cyc_n   = 1'b1;
               stb_n   = 1'b1;
               state_n = BUS;
            end
         end
         BUS: begin
            // ack takes priority over a timeout expiring on the same edge
            if (ack) begin
               cyc_n       = 1'b0;
               stb_n       = 1'b0;
               we_n        = 1'b0;
               rsp_dat_n   = dat_r;
               rsp_err_n   = 1'b0;
               rsp_valid_n = 1'b1;
               state_n     = IDLE;
            end else if (timeout_hit) begin
               cyc_n       = 1'b0;
               stb_n       = 1'b0;
               we_n        = 1'b0;
               rsp_dat_n   = '0;
               rsp_err_n   = 1'b1;
               rsp_valid_n = 1'b1;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cyc       <= 1'b0;
         stb       <= 1'b0;
         we        <= 1'b0;
         adr       <= '0;
         dat_w     <= '0;
         rsp_dat   <= '0;
         rsp_err   <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         state     <= state_n;
         cyc       <= cyc_n;
         stb       <= stb_n;
         we        <= we_n;
         adr       <= adr_n;
         dat_w     <= dat_w_n;
         rsp_dat   <= rsp_dat_n;
         rsp_err   <= rsp_err_n;
         rsp_valid <= rsp_valid_n;
      end
   end

endmodule

// File: tb/tb_wishbone_initiator_bfm.sv
// Bench for wishbone_initiator_bfm against a registered-ack echo target.
module tb_wishbone_initiator_bfm;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_adr = '0;
   logic [DW-1:0] req_dat = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_dat;
   logic          rsp_err;
   logic [AW-1:0] adr;
   logic [DW-1:0] dat_w;
   logic [DW-1:0] dat_r;
   logic          cyc, stb, we, ack;

   logic ack_r;
   logic ack_en = 1'b1;

   always #5 clock = ~clock;

   wishbone_initiator_bfm #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_adr(req_adr), .req_dat(req_dat),
      .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .adr(adr), .dat_w(dat_w), .dat_r(dat_r),
      .cyc(cyc), .stb(stb), .we(we), .ack(ack)
   );

   // target: registered ack gated by the live strobe, read data echoes dat_w
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) ack_r <= 1'b0;
      else        ack_r <= stb & cyc;
   end
   assign ack   = ack_r & cyc & stb & ack_en;
   assign dat_r = dat_w;

   int errors = 0;
   int checks = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      logic [DW-1:0] exp_rsp;
      int            exp_lat;
   } vec_t;

   vec_t vecs[5];

   task automatic run_cmd(input vec_t v, input string tag);
      int edges;
      bit seen;
      @(negedge clock);
      req_valid = 1'b1; req_we = v.we; req_adr = v.adr; req_dat = v.dat;
      check({tag, " req_ready"}, req_ready, 1);
      @(posedge clock); #1;
      req_valid = 1'b0;
      check({tag, " cyc"}, cyc, 1);
      check({tag, " stb"}, stb, 1);
      check({tag, " we"}, we, v.we);
      check({tag, " adr"}, adr, v.adr);
      check({tag, " dat_w"}, dat_w, v.dat);
      edges = 0; seen = 0;
      while (!seen && edges < 40) begin
         @(posedge clock); #1;
         edges++;
         if (rsp_valid) seen = 1;
      end
      check({tag, " rsp_seen"}, seen, 1);
      check({tag, " latency"}, edges, v.exp_lat);
      check({tag, " rsp_dat"}, rsp_dat, v.exp_rsp);
      check({tag, " cyc_drop"}, cyc, 0);
      @(posedge clock); #1;
      check({tag, " rsp_pulse"}, rsp_valid, 0);
      check({tag, " adr_hold"}, adr, v.adr);
   endtask

   initial begin
      int bad, acc, rsp_cnt, ack_cnt, rises, edges;
      bit prev_cyc, seen;
      logic [DW-1:0] b2b_dat [4];
      vec_t v;

      vecs[0] = '{we:1'b1, adr:32'h0000_1000, dat:32'hDEAD_BEEF, exp_rsp:32'hDEAD_BEEF, exp_lat:2};
      vecs[1] = '{we:1'b0, adr:32'h0000_0004, dat:32'h1234_5678, exp_rsp:32'h1234_5678, exp_lat:2};
      vecs[2] = '{we:1'b1, adr:32'hFFFF_FFFC, dat:32'h0000_0000, exp_rsp:32'h0000_0000, exp_lat:2};
      vecs[3] = '{we:1'b0, adr:32'h0000_0000, dat:32'hFFFF_FFFF, exp_rsp:32'hFFFF_FFFF, exp_lat:2};
      vecs[4] = '{we:1'b1, adr:32'hA5A5_0000, dat:32'h5A5A_5A5A, exp_rsp:32'h5A5A_5A5A, exp_lat:2};

      // reset held 50ns, outputs quiet throughout
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (cyc !== 1'b0 || stb !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) bad++;
      end
      check("reset_quiet", bad, 0);
      check("reset_adr", adr, 0);
      check("reset_dat_w", dat_w, 0);
      check("reset_rsp_dat", rsp_dat, 0);
      check("reset_rsp_err", rsp_err, 0);
      reset = 1'b1;
      @(negedge clock);
      check("post_reset_ready", req_ready, 1);
      check("post_reset_cyc", cyc, 0);

      for (int i = 0; i < 5; i++) begin
         run_cmd(vecs[i], $sformatf("vec%0d", i));
         check($sformatf("vec%0d rsp_err", i), rsp_err, 0);
      end

      // req_valid held high for four commands
      for (int i = 0; i < 4; i++) b2b_dat[i] = 32'h1111_0000 + 32'(i * 32'h0101);
      acc = 0; rsp_cnt = 0; ack_cnt = 0; rises = 0; prev_cyc = 0; bad = 0;
      @(posedge clock); #1;
      req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h0; req_dat = b2b_dat[0];
      for (int c = 0; c < 24; c++) begin
         @(negedge clock);
         if (cyc && !prev_cyc) rises++;
         prev_cyc = cyc;
         if (ack) ack_cnt++;
         if (rsp_valid) begin
            if (cyc !== 1'b0) bad++;
            if (rsp_cnt < 4) check($sformatf("b2b rsp_dat%0d", rsp_cnt), rsp_dat, b2b_dat[rsp_cnt]);
            rsp_cnt++;
         end
         if (req_valid && req_ready) begin
            @(posedge clock); #1;
            acc++;
            if (acc == 4) req_valid = 1'b0;
            else begin
               req_we = acc[0]; req_adr = 32'(acc * 4); req_dat = b2b_dat[acc];
            end
         end
      end
      check("b2b accepts", acc, 4);
      check("b2b rsp_count", rsp_cnt, 4);
      check("b2b ack_count", ack_cnt, 4);
      check("b2b cyc_rises", rises, 4);
      check("b2b rsp_while_cyc", bad, 0);

      // reset asserted in the middle of a bus cycle
      @(negedge clock);
      req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h0000_0BAD; req_dat = 32'hCAFE_F00D;
      @(posedge clock); #1;
      req_valid = 1'b0;
      check("midrst cyc_before", cyc, 1);
      #2 reset = 1'b0;
      #1;
      check("midrst cyc_drop", cyc, 0);
      check("midrst stb_drop", stb, 0);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (rsp_valid !== 1'b0) bad++;
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (rsp_valid !== 1'b0 || cyc !== 1'b0) bad++;
      end
      check("midrst no_rsp", bad, 0);
      run_cmd(vecs[1], "after_rst");

      // target withholds ack
      ack_en = 1'b0;
      v = '{we:1'b0, adr:32'h0000_0040, dat:32'h0BAD_CAFE, exp_rsp:32'h0, exp_lat:8};
`ifdef WB_INIT_TIMEOUT_EN
      run_cmd(v, "timeout");
      check("timeout rsp_err", rsp_err, 1);
      ack_en = 1'b1;
      run_cmd(vecs[0], "after_timeout");
      check("after_timeout rsp_err", rsp_err, 0);
`else
      @(negedge clock);
      req_valid = 1'b1; req_we = v.we; req_adr = v.adr; req_dat = v.dat;
      @(posedge clock); #1;
      req_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clock); #1;
         if (cyc !== 1'b1 || stb !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b0) bad++;
      end
      check("stall hold", bad, 0);
      ack_en = 1'b1;
      edges = 0; seen = 0;
      while (!seen && edges < 40) begin
         @(posedge clock); #1;
         edges++;
         if (rsp_valid) seen = 1;
      end
      check("stall rsp_seen", seen, 1);
      check("stall latency", edges, 1);
      check("stall rsp_dat", rsp_dat, 32'h0BAD_CAFE);
      check("stall rsp_err", rsp_err, 0);
      run_cmd(vecs[3], "after_stall");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

endmodule
